// File: rtl/clk_1_module.sv
// Input stage of the CRC pipeline: gathers 15 nibbles into a 60-bit job, issues it downstream and
// registers the returned result. Define CRC_IN_TIMEOUT_EN to discard partial frames after pGAP_MAX idle cycles.
`timescale 1ns/1ps
module clk_1_module #(
    parameter int unsigned pGAP_MAX = 16
) (
    input  logic        clk_1,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_data,
    input  logic        in_CRC,
    input  logic        in_mode,
    output logic [59:0] clk1_message,
    output logic        clk1_CRC,
    output logic        clk1_mode,
    output logic        clk1_flag,
    input  logic [59:0] clk2_out,
    input  logic        clk2_flag,
    output logic        out_valid,
    output logic [59:0] out_data,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2,
        WAIT    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [59:0] msg_q, msg_d;
    logic        crc_q, crc_d;
    logic        mode_q, mode_d;
    logic        flag_q, flag_d;
    logic [59:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        accept;

    // A zero limit would time out a frame before it could ever receive a second beat.
    if (pGAP_MAX < 1) begin : g_bad_gap_max
        $error("clk_1_module: pGAP_MAX must be at least 1");
    end

    assign in_ready = (state_q == IDLE) || (state_q == COLLECT);
    assign accept   = in_valid && in_ready;

`ifdef CRC_IN_TIMEOUT_EN
    localparam int unsigned GAP_W = $clog2(pGAP_MAX + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(pGAP_MAX - 1);

    logic [GAP_W-1:0] gap_q, gap_d;
    logic             tmo_q, tmo_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        msg_d       = msg_q;
        crc_d       = crc_q;
        mode_d      = mode_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
`ifdef CRC_IN_TIMEOUT_EN
        gap_d       = '0;
        tmo_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    crc_d   = in_CRC;
                    mode_d  = in_mode;
                    msg_d   = {msg_q[55:0], in_data};
                    cnt_d   = 4'd1;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    msg_d = {msg_q[55:0], in_data};
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd14) begin
                        state_d = ISSUE;
                    end
                end
`ifdef CRC_IN_TIMEOUT_EN
                // The pGAP_MAX-th consecutive empty cycle drops the partial frame.
                else if (gap_q == GAP_LAST) begin
                    cnt_d   = 4'd0;
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
`endif
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (clk2_flag) begin
                    out_data_d  = clk2_out;
                    out_valid_d = 1'b1;
                    cnt_d       = 4'd0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        flag_d = (state_d == ISSUE);
    end

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            msg_q       <= '0;
            crc_q       <= 1'b0;
            mode_q      <= 1'b0;
            flag_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            msg_q       <= msg_d;
            crc_q       <= crc_d;
            mode_q      <= mode_d;
            flag_q      <= flag_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef CRC_IN_TIMEOUT_EN
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            gap_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            gap_q <= gap_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign clk1_message = msg_q;
    assign clk1_CRC     = crc_q;
    assign clk1_mode    = mode_q;
    assign clk1_flag    = flag_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;

endmodule
